// File: rtl/vmul_collect.sv
// Collects NUMCHUNKS narrow multiplier chunks into one full-width vector,
// tagged with the destination register and lane mask of its first chunk.
module vmul_collect #(
  parameter int LOG2WIDTH    = 5,
  parameter int NUMMULLANES  = 4,
  parameter int LOG2NUMLANES = 4,
  parameter int REGIDWIDTH   = 4
) (
  input  logic                                         clk,
  input  logic                                         resetn,
  input  logic                                         in_valid,
  output logic                                         in_ready,
  input  logic                                         in_first,
  input  logic [NUMMULLANES*(2**LOG2WIDTH)-1:0]        in_data,
  input  logic [REGIDWIDTH-1:0]                        in_dst,
  input  logic                                         in_dst_we,
  input  logic [(2**LOG2NUMLANES)-1:0]                 in_mask,
  output logic                                         out_valid,
  input  logic                                         out_ready,
  output logic [(2**LOG2NUMLANES)*(2**LOG2WIDTH)-1:0]  out_data,
  output logic [REGIDWIDTH-1:0]                        out_dst,
  output logic                                         out_dst_we,
  output logic [(2**LOG2NUMLANES)-1:0]                 out_dst_mask,
  output logic                                         busy,
  output logic                                         err
);

  localparam int WIDTH     = 2**LOG2WIDTH;
  localparam int NUMLANES  = 2**LOG2NUMLANES;
  localparam int NUMCHUNKS = NUMLANES / NUMMULLANES;
  localparam int CHUNK_W   = NUMMULLANES * WIDTH;
  localparam int VEC_W     = NUMLANES * WIDTH;
  localparam int CNT_W     = (NUMCHUNKS > 1) ? $clog2(NUMCHUNKS) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    FULL    = 2'd2
  } state_t;

  function automatic logic [VEC_W-1:0] mask_lanes(input logic [VEC_W-1:0]    data,
                                                  input logic [NUMLANES-1:0] mask);
    logic [VEC_W-1:0] res;
    res = '0;
    for (int l = 0; l < NUMLANES; l++)
      res[l*WIDTH +: WIDTH] = mask[l] ? data[l*WIDTH +: WIDTH] : '0;
    return res;
  endfunction

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               acc, take, start, wr_en, err_nxt;
  logic [CNT_W-1:0]   wr_chunk;

  logic [VEC_W-1:0]      lanes_p0;
  logic [REGIDWIDTH-1:0] dst_p0;
  logic                  we_p0;
  logic [NUMLANES-1:0]   mask_p0;

  // FULL only accepts a chunk in the same cycle the held vector is taken.
  assign in_ready = (state != FULL) | out_ready;
  assign acc      = in_valid & in_ready;
  assign take     = out_valid & out_ready;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    start     = 1'b0;
    wr_en     = 1'b0;
    wr_chunk  = cnt;
    err_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (acc) begin
          if (in_first) start   = 1'b1;
          else          err_nxt = 1'b1;
        end
      end
      COLLECT: begin
        if (acc) begin
          if (in_first) begin
            start   = 1'b1;
            err_nxt = 1'b1;
          end else begin
            wr_en = 1'b1;
            if (cnt == CNT_W'(NUMCHUNKS - 1)) begin
              state_nxt = FULL;
              cnt_nxt   = '0;
            end else begin
              cnt_nxt = cnt + CNT_W'(1);
            end
          end
        end
      end
      FULL: begin
        if (take) begin
          state_nxt = IDLE;
          if (acc) begin
            if (in_first) start   = 1'b1;
            else          err_nxt = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (start) begin
      wr_en    = 1'b1;
      wr_chunk = '0;
      if (NUMCHUNKS == 1) begin
        state_nxt = FULL;
        cnt_nxt   = '0;
      end else begin
        state_nxt = COLLECT;
        cnt_nxt   = CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      out_valid <= (state_nxt == FULL);
      busy      <= (state_nxt != IDLE);
      err       <= err_nxt;
    end
  end

  // Stage p0: lane buffer and vector tags; never written while FULL is stalled.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lanes_p0 <= '0;
      dst_p0   <= '0;
      we_p0    <= 1'b0;
      mask_p0  <= '0;
    end else begin
      if (wr_en) begin
        for (int c = 0; c < NUMCHUNKS; c++)
          if (wr_chunk == CNT_W'(c))
            lanes_p0[c*CHUNK_W +: CHUNK_W] <= in_data;
      end
      if (start) begin
        dst_p0  <= in_dst;
        we_p0   <= in_dst_we;
        mask_p0 <= in_mask;
      end
    end
  end

  assign out_data     = mask_lanes(lanes_p0, mask_p0);
  assign out_dst      = dst_p0;
  assign out_dst_we   = we_p0;
  assign out_dst_mask = mask_p0;

endmodule
